// File: rtl/divisor_sequencial.sv
// divisor_sequencial: sequential restoring divider, one quotient bit per clock.
//   Divides a 2n-bit dividend by an n-bit divisor (unsigned).
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous active-high reset
//     init      start request, honoured in IDLE or DONE
//     A [2n]    dividend, captured on the start edge
//     B [n]     divisor, captured on the start edge
//     Q [n]     quotient   (valid while finish=1)
//     R [n]     remainder  (valid while finish=1)
//     finish    high in DONE
//     div_zero  divisor was zero
//     overflow  quotient would not fit in n bits
//   Internally split into a control unit (FSM + iteration counter) and a
//   datapath (working registers, subtractor, muxes).

// ---------------------------------------------------------------------------
// Control unit: sequences load -> check -> n iterations -> done.
// ---------------------------------------------------------------------------
module divisor_sequencial_ctrl #(
  parameter int n = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_init,
  input  logic i_rb_zero,
  input  logic i_rh_ge_rb,
  output logic o_load,
  output logic o_set_zero,
  output logic o_set_ovf,
  output logic o_iter,
  output logic o_finish
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    o_load       = 1'b0;
    o_set_zero   = 1'b0;
    o_set_ovf    = 1'b0;
    o_iter       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_init) begin
          o_load       = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_rb_zero) begin
          o_set_zero   = 1'b1;
          w_state_next = S_DONE;
        end else if (i_rh_ge_rb) begin
          // High half already >= divisor: quotient needs more than n bits.
          o_set_ovf    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_count_next = CW'(n);
          w_state_next = S_ITER;
        end
      end
      S_ITER: begin
        o_iter       = 1'b1;
        w_count_next = r_count - CW'(1);
        // Last quotient bit is produced on the edge the counter hits zero.
        if (r_count == CW'(1)) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_finish = (r_state == S_DONE);
endmodule

// ---------------------------------------------------------------------------
// Datapath: RH:RL working pair, divisor register, trial subtractor, flags.
// ---------------------------------------------------------------------------
module divisor_sequencial_dp #(
  parameter int n = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_set_zero,
  input  logic           i_set_ovf,
  input  logic           i_iter,
  input  logic [2*n-1:0] i_a,
  input  logic [n-1:0]   i_b,
  output logic           o_rb_zero,
  output logic           o_rh_ge_rb,
  output logic [n-1:0]   o_q,
  output logic [n-1:0]   o_r,
  output logic           o_div_zero,
  output logic           o_overflow
);
  logic [n-1:0] r_rh, r_rl, r_rb;
  logic         r_div_zero, r_overflow;

  // Shift {RH,RL} left by one; the bit leaving RH becomes the extra MSB of
  // the n+1-bit partial remainder so the trial subtraction cannot lose it.
  logic [n-1:0] w_sh_rh;
  logic [n:0]   w_partial;
  logic [n:0]   w_diff;
  logic         w_fits;

  assign w_sh_rh   = {r_rh[n-2:0], r_rl[n-1]};
  assign w_partial = {r_rh[n-1], w_sh_rh};
  assign w_diff    = w_partial - {1'b0, r_rb};
  assign w_fits    = (w_partial >= {1'b0, r_rb});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rh       <= '0;
      r_rl       <= '0;
      r_rb       <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_load) begin
      r_rh       <= i_a[2*n-1:n];
      r_rl       <= i_a[n-1:0];
      r_rb       <= i_b;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_set_zero) begin
      r_rl       <= '1;
      r_rh       <= '0;
      r_div_zero <= 1'b1;
    end else if (i_set_ovf) begin
      r_rl       <= '1;
      r_rh       <= '0;
      r_overflow <= 1'b1;
    end else if (i_iter) begin
      // Restore on a negative trial: keep the shifted value, quotient bit 0.
      r_rh <= w_fits ? w_diff[n-1:0] : w_sh_rh;
      r_rl <= {r_rl[n-2:0], w_fits};
    end
  end

  assign o_rb_zero  = (r_rb == '0);
  assign o_rh_ge_rb = (r_rh >= r_rb);
  assign o_q        = r_rl;
  assign o_r        = r_rh;
  assign o_div_zero = r_div_zero;
  assign o_overflow = r_overflow;
endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module divisor_sequencial #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic [2*n-1:0] A,
  input  logic [n-1:0]   B,
  output logic [n-1:0]   Q,
  output logic [n-1:0]   R,
  output logic           finish,
  output logic           div_zero,
  output logic           overflow
);
  logic w_load, w_set_zero, w_set_ovf, w_iter;
  logic w_rb_zero, w_rh_ge_rb;

  divisor_sequencial_ctrl #(.n(n)) u_ctrl (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_init     (init),
    .i_rb_zero  (w_rb_zero),
    .i_rh_ge_rb (w_rh_ge_rb),
    .o_load     (w_load),
    .o_set_zero (w_set_zero),
    .o_set_ovf  (w_set_ovf),
    .o_iter     (w_iter),
    .o_finish   (finish)
  );

  divisor_sequencial_dp #(.n(n)) u_dp (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_set_zero (w_set_zero),
    .i_set_ovf  (w_set_ovf),
    .i_iter     (w_iter),
    .i_a        (A),
    .i_b        (B),
    .o_rb_zero  (w_rb_zero),
    .o_rh_ge_rb (w_rh_ge_rb),
    .o_q        (Q),
    .o_r        (R),
    .o_div_zero (div_zero),
    .o_overflow (overflow)
  );
endmodule

// File: tb/tb_divisor_sequencial.sv
// Testbench for divisor_sequencial (n=8): directed vector table, hand-written
// corner sequences (init toggling, restart from DONE, mid-operation reset)
// and randomised operations checked against an arithmetic reference model.
module tb_divisor_sequencial;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic [N-1:0]   Q, R;
  logic           finish, div_zero, overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divisor_sequencial #(.n(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .finish   (finish),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division plus the error rules.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
    int ai, bi;
    ai = a; bi = b;
    dz = 0; ov = 0;
    if (bi == 0) begin
      dz = 1; q = 8'hFF; r = 8'h00; lat = 1;
    end else if ((ai / 256) >= bi) begin
      ov = 1; q = 8'hFF; r = 8'h00; lat = 1;
    end else begin
      q = 8'(ai / bi); r = 8'(ai % bi); lat = N + 1;
    end
  endtask

  // Presents operands, issues the start edge (edge 0) and checks that finish
  // is low afterwards. Returns at the negedge following edge 0.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    A = a; B = b; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    A = 16'($urandom); B = 8'($urandom);  // operands may change after start
    check("finish_low_after_start", finish, 0);
  endtask

  // Counts edges after edge 0 until finish is seen; -1 if the bound expires.
  task automatic wait_finish(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (finish) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic edz, input logic eov, input int elat);
    int lat;
    start_op(a, b);
    wait_finish(lat);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_Q"}, Q, eq);
    check({tag, "_R"}, R, er);
    check({tag, "_div_zero"}, div_zero, edz);
    check({tag, "_overflow"}, overflow, eov);
    $display("op %s A=%0d B=%0d -> Q=%0d R=%0d dz=%0b ov=%0b lat=%0d",
             tag, a, b, Q, R, div_zero, overflow, lat);
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0]  eq, er;
    logic        edz, eov;
    int          elat, lat;
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0] = '{a: 16'd1000,  b: 8'd7,    q: 8'd142, r: 8'd6,   dz: 0, ov: 0, lat: 9};
    vecs[1] = '{a: 16'hFEFF,  b: 8'hFF,   q: 8'd255, r: 8'd254, dz: 0, ov: 0, lat: 9};
    vecs[2] = '{a: 16'h1234,  b: 8'd0,    q: 8'hFF,  r: 8'd0,   dz: 1, ov: 0, lat: 1};
    vecs[3] = '{a: 16'h0500,  b: 8'd5,    q: 8'hFF,  r: 8'd0,   dz: 0, ov: 1, lat: 1};
    vecs[4] = '{a: 16'd100,   b: 8'd10,   q: 8'd10,  r: 8'd0,   dz: 0, ov: 0, lat: 9};

    reset = 1'b1; init = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_finish", finish, 0);
    check("reset_Q", Q, 0);
    check("reset_R", R, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Directed table (back-to-back: each restart comes straight from DONE).
    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
                    vecs[i].r, vecs[i].dz, vecs[i].ov, vecs[i].lat);
    end

    // init toggled during CHECK/ITER must not restart the operation.
    start_op(16'd1000, 8'd7);
    for (int e = 1; e <= 9; e++) begin
      init = (e < 9) ? 1'(e % 2) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (e < 9) check($sformatf("toggle_finish_low_e%0d", e), finish, 0);
    end
    init = 1'b0;
    check("toggle_finish", finish, 1);
    check("toggle_Q", Q, 142);
    check("toggle_R", R, 6);
    $display("op toggle A=1000 B=7 -> Q=%0d R=%0d finish=%0b", Q, R, finish);
    run_and_check("restart_from_done", 16'd0, 8'd5, 8'd0, 8'd0, 0, 0, 9);

    // Asynchronous reset between edges 4 and 5.
    start_op(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_finish", finish, 0);
    check("midreset_Q", Q, 0);
    check("midreset_R", R, 0);
    check("midreset_div_zero", div_zero, 0);
    check("midreset_overflow", overflow, 0);
    $display("op midreset -> Q=%0d R=%0d finish=%0b", Q, R, finish);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset_finish", finish, 0);
    run_and_check("after_reset", 16'd100, 8'd10, 8'd10, 8'd0, 0, 0, 9);

    // Randomised: in-range operands, verified by the multiplication identity.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      if (ra[15:8] == 8'hFF) ra[15:8] = 8'($urandom_range(0, 254));
      rb = 8'($urandom_range(int'(ra[15:8]) + 1, 255));
      ref_div(ra, rb, eq, er, edz, eov, elat);
      start_op(ra, rb);
      wait_finish(lat);
      check("rand_latency", lat, elat);
      check("rand_identity", longint'(Q) * longint'(rb) + longint'(R), longint'(ra));
      check("rand_r_lt_b", (R < rb), 1);
      check("rand_Q", Q, eq);
      check("rand_flags", {div_zero, overflow}, {edz, eov});
      $display("op rand%0d A=%0d B=%0d -> Q=%0d R=%0d lat=%0d", i, ra, rb, Q, R, lat);
    end

    // Randomised unrestricted operands, including divide-by-zero and overflow.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? 8'd0 : 8'($urandom);
      ref_div(ra, rb, eq, er, edz, eov, elat);
      run_and_check($sformatf("any%0d", i), ra, rb, eq, er, edz, eov, elat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
